// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and default sizing for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } btn_state_e;

    localparam int DEF_DB_CYCLES = 4;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/btn_press_pulser_sync2.sv
// rtl/btn_press_pulser_sync2.sv - two-flop synchroniser, async active-low reset to 0
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_press_pulser.sv
// rtl/btn_press_pulser.sv - synchronise/debounce a raw button into press/release pulses (long press under BTN_LONG_PRESS_EN)
module btn_press_pulser
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
`ifdef BTN_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync;
    btn_state_e       state;
    btn_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter only advances below DB_LAST, so it can never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_DB: begin
                if (sync) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state edge.
    always_comb begin
        level_nxt   = (state_nxt == HELD) || (state_nxt == RELEASE_DB);
        press_nxt   = (state == PRESS_DB) && (state_nxt == HELD);
        release_nxt = (state == RELEASE_DB) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] long_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_cnt <= '0;
        end else if ((state != HELD) && (state_nxt == HELD)) begin
            long_cnt <= '0;
        end else if ((state == HELD) && (long_cnt != '1)) begin
            long_cnt <= long_cnt + CNT_W'(1);
        end
    end

    // Sticky across a release bounce; only a return to IDLE clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_press <= 1'b0;
        end else if (state_nxt == IDLE) begin
            long_press <= 1'b0;
        end else if (long_cnt >= LONG_LAST) begin
            long_press <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_btn_press_pulser.sv
// tb/tb_btn_press_pulser.sv - directed self-checking bench for btn_press_pulser
module tb_btn_press_pulser;

    logic clk;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
`ifdef BTN_LONG_PRESS_EN
    logic long_press;
`endif

    int checks;
    int failures;
    int press_cnt;
    int release_cnt;

    btn_press_pulser dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
`ifdef BTN_LONG_PRESS_EN
        ,
        .long_press    (long_press)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (press_pulse === 1'b1) begin
            press_cnt++;
            check("pulse_overlap", 32'(release_pulse), 0);
        end
        if (release_pulse === 1'b1) release_cnt++;
    end

    // Call right after raising btn_raw between edges; the next edge is the first sample.
    task automatic expect_press(input string tag);
        repeat (6) tick();
        check({tag, "_early"}, 32'(press_pulse), 0);
        check({tag, "_lvl_early"}, 32'(btn_level), 0);
        tick();
        check({tag, "_pulse"}, 32'(press_pulse), 1);
        check({tag, "_lvl"}, 32'(btn_level), 1);
        tick();
        check({tag, "_single"}, 32'(press_pulse), 0);
    endtask

    task automatic expect_release(input string tag);
        repeat (6) tick();
        check({tag, "_early"}, 32'(release_pulse), 0);
        check({tag, "_lvl_early"}, 32'(btn_level), 1);
        tick();
        check({tag, "_pulse"}, 32'(release_pulse), 1);
        check({tag, "_lvl"}, 32'(btn_level), 0);
        tick();
        check({tag, "_single"}, 32'(release_pulse), 0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        press_cnt   = 0;
        release_cnt = 0;
        rst         = 1'b0;
        btn_raw     = 1'b1;

        // 1: reset held with button high, then press detected from reset release
        tick();
        check("t1_rst_lvl", 32'(btn_level), 0);
        check("t1_rst_press", 32'(press_pulse), 0);
        check("t1_rst_rel", 32'(release_pulse), 0);
`ifdef BTN_LONG_PRESS_EN
        check("t1_rst_long", 32'(long_press), 0);
`endif
        tick();
        check("t1_rst_lvl2", 32'(btn_level), 0);
        check("t1_rst_press2", 32'(press_pulse), 0);
        rst = 1'b1;
        expect_press("t1_press");
        btn_raw = 1'b0;
        expect_release("t1_rel");

        // 2: clean 20-cycle press
        btn_raw = 1'b1;
        expect_press("t2_press");
        repeat (12) tick();
        check("t2_hold_lvl", 32'(btn_level), 1);
        btn_raw = 1'b0;
        expect_release("t2_rel");
        check("t2_press_cnt", 32'(press_cnt), 2);
        check("t2_rel_cnt", 32'(release_cnt), 2);

        // 3: bounce 1,1,0 never reaches HELD
        for (int i = 0; i < 10; i++) begin
            btn_raw = 1'b1;
            tick();
            tick();
            btn_raw = 1'b0;
            tick();
            check("t3_lvl", 32'(btn_level), 0);
        end
        repeat (4) tick();
        check("t3_press_cnt", 32'(press_cnt), 2);
        check("t3_lvl_end", 32'(btn_level), 0);

        // 4: release bounce low 2, high 1, then steady low
        btn_raw = 1'b1;
        expect_press("t4_press");
        repeat (2) tick();
        btn_raw = 1'b0;
        tick();
        check("t4_lvl1", 32'(btn_level), 1);
        tick();
        check("t4_lvl2", 32'(btn_level), 1);
        btn_raw = 1'b1;
        tick();
        check("t4_lvl3", 32'(btn_level), 1);
        btn_raw = 1'b0;
        for (int i = 4; i < 10; i++) begin
            tick();
            check("t4_lvl_hold", 32'(btn_level), 1);
            check("t4_rel_early", 32'(release_pulse), 0);
        end
        tick();
        check("t4_rel_pulse", 32'(release_pulse), 1);
        check("t4_lvl_low", 32'(btn_level), 0);
        tick();
        check("t4_rel_single", 32'(release_pulse), 0);
        check("t4_press_cnt", 32'(press_cnt), 3);
        check("t4_rel_cnt", 32'(release_cnt), 3);

        // 5: reset mid-debounce and mid-hold
        btn_raw = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("t5a_lvl", 32'(btn_level), 0);
        check("t5a_press", 32'(press_pulse), 0);
        tick();
        tick();
        check("t5a_press_cnt", 32'(press_cnt), 3);
        rst = 1'b1;
        expect_press("t5_press_a");
        tick();
        rst = 1'b0;
        #1;
        check("t5b_lvl", 32'(btn_level), 0);
        check("t5b_rel", 32'(release_pulse), 0);
        btn_raw = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (8) tick();
        check("t5b_rel_cnt", 32'(release_cnt), 3);
        check("t5b_press_cnt", 32'(press_cnt), 4);
        check("t5b_lvl_idle", 32'(btn_level), 0);
        btn_raw = 1'b1;
        expect_press("t5_press_b");
        check("t5c_press_cnt", 32'(press_cnt), 5);
        btn_raw = 1'b0;
        expect_release("t5_rel");
        check("t5c_rel_cnt", 32'(release_cnt), 4);

`ifdef BTN_LONG_PRESS_EN
        // 6: long press over a 30-cycle hold, none for a 10-cycle hold
        btn_raw = 1'b1;
        repeat (23) tick();
        check("t6_long_early", 32'(long_press), 0);
        tick();
        check("t6_long_rise", 32'(long_press), 1);
        repeat (6) tick();
        btn_raw = 1'b0;
        repeat (6) tick();
        check("t6_long_kept", 32'(long_press), 1);
        tick();
        check("t6_long_clear", 32'(long_press), 0);
        check("t6_rel_pulse", 32'(release_pulse), 1);
        tick();
        btn_raw = 1'b1;
        repeat (10) tick();
        check("t6_short_hold", 32'(long_press), 0);
        btn_raw = 1'b0;
        repeat (10) tick();
        check("t6_short_after", 32'(long_press), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_press_pulser.md
Name: btn_press_pulser

Overview:
Upstream front end for the toggle FSM. Conditions a raw, asynchronous, bouncy push-button input into a clean single-cycle press pulse that drives the toggle FSM's `x` input. Stages, in order:
- two-flop synchroniser;
- debounce state machine with a stability counter;
- registered press/release pulse outputs.

Parameters:
- DB_CYCLES, 4: consecutive stable synchronised samples required to accept a press or a release. Legal range 2..255.
- CNT_W, 8: debounce counter width. Must satisfy 2^CNT_W > DB_CYCLES.
- LONG_CYCLES, 16: held-duration threshold for long-press detection. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- btn_raw  in  1  raw button level, asynchronous to clk, may bounce.
- btn_level  out  1  debounced button level.
- press_pulse  out  1  one-cycle pulse on accepted press; feeds the toggle FSM `x`.
- release_pulse  out  1  one-cycle pulse on accepted release.
- long_press  out  1  long-press indication. Present only with BTN_LONG_PRESS_EN.

Behaviour:
- Reset: rst low immediately clears all state.
  - Synchroniser flops = 0, state = IDLE, counter = 0.
  - btn_level = press_pulse = release_pulse = long_press = 0.
  - Reset release is taken synchronously at the next clk edge with rst high.
- Synchroniser: sync = btn_raw delayed by 2 clk edges. The FSM sees only sync.
- States: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE:
  - sync=1 -> PRESS_DB, cnt=0.
  - Otherwise stay.
- PRESS_DB:
  - sync=0 -> IDLE, cnt=0. This is a glitch; no pulse.
  - sync=1 and cnt==DB_CYCLES-1 -> HELD.
  - Otherwise cnt+1.
- HELD:
  - sync=0 -> RELEASE_DB, cnt=0.
  - Otherwise stay.
- RELEASE_DB:
  - sync=1 -> HELD, cnt=0. No new press_pulse.
  - sync=0 and cnt==DB_CYCLES-1 -> IDLE.
  - Otherwise cnt+1.
- Outputs are all registered:
  - btn_level = 1 exactly while state is HELD or RELEASE_DB.
  - press_pulse = 1 for exactly the one cycle following the PRESS_DB->HELD edge.
  - release_pulse = 1 for exactly the one cycle following the RELEASE_DB->IDLE edge.
- Latency: btn_raw first sampled high at edge n and held stable gives press_pulse high between edges n+2+DB_CYCLES and n+3+DB_CYCLES. With DB_CYCLES=4 that is edges n+6 to n+7.
- Release latency is symmetric.
- press_pulse and release_pulse are never high together.
- There are never two press_pulses without an intervening release_pulse.
- Counter saturates by construction: it never exceeds DB_CYCLES-1 and never wraps.
- Reset mid-debounce or mid-hold: no pulse is emitted. The next press requires a full IDLE->PRESS_DB->HELD sequence.
- Unreachable state encodings -> IDLE.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- Defined:
  - A second counter (same width as CNT_W, saturating) counts cycles in HELD and clears on entry to HELD.
  - long_press goes 1 the cycle after the count reaches LONG_CYCLES and stays 1 until the state leaves HELD/RELEASE_DB to IDLE or reset.
  - A RELEASE_DB bounce back to HELD does not clear it.
- Not defined: the long_press port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package `btn_pkg`: 2-bit state encoding constants IDLE=0, PRESS_DB=1, HELD=2, RELEASE_DB=3, plus default DB_CYCLES/CNT_W values.
- One sub-module: `sync2`, the two-flop synchroniser with async active-low reset to 0.
- The FSM, counters and output registers live in the top module.

Test Plan (DB_CYCLES=4, LONG_CYCLES=16, clk period 10):
1. rst=0 for 2 cycles with btn_raw=1 -> all outputs 0 throughout. After release, the press is detected normally: press_pulse high for exactly 1 cycle, at the 6th edge after btn_raw is first sampled high at an edge with rst high.
2. Clean press: btn_raw 0->1 held 20 cycles, then 0 -> press_pulse one cycle at edge n+6; btn_level 1 from the same point. After the release, release_pulse one cycle 6 edges after btn_raw is first sampled low.
3. Bounce: btn_raw high 2 cycles, low 1, high 2, low, repeated for 30 cycles -> press_pulse never asserts; btn_level stays 0.
4. Release bounce: hold 10 cycles, then low 2 cycles, high 1, then steady low -> exactly one press_pulse and one release_pulse; btn_level never drops during the 2-cycle low.
5. Assert rst during PRESS_DB (3 stable cycles) and again during HELD -> outputs 0 immediately, no pulse emitted; the subsequent clean press yields exactly one press_pulse.
6. With BTN_LONG_PRESS_EN, hold 30 cycles -> long_press rises the cycle after the hold count reaches 16. It clears after IDLE is reached, and stays 0 for a 10-cycle hold.
